// File: rtl/seg_scan_ctrl.sv
// Kitchen-timer display controller: scans a 4-digit common-anode 7-segment
// display, converts min/sec to BCD with a subtract-by-ten divider, and blinks.
`timescale 1ns/1ps
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       time_up,
    input  logic       paused,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       conv_busy
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MIN_DIV,
        S_SEC_DIV
    } conv_state_t;

    logic [PW-1:0]     presc_q, presc_d;
    logic [1:0]        idx_q, idx_d;
    logic              first_q, first_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              blink_phase_q, blink_phase_d;
    conv_state_t       state_q, state_d;
    logic [5:0]        rem_q, rem_d;
    logic [3:0]        tens_q, tens_d;
    logic [5:0]        sec_snap_q, sec_snap_d;
    // Digit order matches the scan index: {min tens, min ones, sec tens, sec ones}
    logic [3:0][3:0]   pend_q, pend_d;
    logic [3:0][3:0]   disp_q, disp_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic presc_tc;
    logic frame_start;
    logic blank;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] s;
        case (digit)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign presc_tc    = (presc_q == PRESC_LAST);
    assign frame_start = first_q | (presc_tc & (idx_q == 2'd3));
    assign blank       = (time_up | paused) & ~blink_phase_q;

    // Scan timing, frame commit and blink pacing
    always_comb begin
        presc_d       = presc_tc ? '0 : presc_q + 1'b1;
        idx_d         = presc_tc ? idx_q + 2'd1 : idx_q;
        first_d       = 1'b0;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        disp_d        = disp_q;
        if (frame_start) begin
            disp_d = pend_q;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Converter: one subtract-by-ten per cycle, min first, then sec
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        tens_d     = tens_q;
        sec_snap_d = sec_snap_q;
        pend_d     = pend_q;
        if (frame_start) begin
            state_d    = S_MIN_DIV;
            rem_d      = min;
            tens_d     = 4'd0;
            sec_snap_d = sec;
        end else begin
            case (state_q)
                S_MIN_DIV: begin
                    if (rem_q >= 6'd10) begin
                        rem_d  = rem_q - 6'd10;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        pend_d[3] = tens_q;
                        pend_d[2] = rem_q[3:0];
                        state_d   = S_SEC_DIV;
                        rem_d     = sec_snap_q;
                        tens_d    = 4'd0;
                    end
                end
                S_SEC_DIV: begin
                    if (rem_q >= 6'd10) begin
                        rem_d  = rem_q - 6'd10;
                        tens_d = tens_q + 4'd1;
                    end else begin
                        pend_d[1] = tens_q;
                        pend_d[0] = rem_q[3:0];
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (!blank) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = seg_encode(disp_q[idx_q]);
            dp_d  = (idx_q != 2'd2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q       <= '0;
            idx_q         <= 2'd0;
            first_q       <= 1'b1;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            state_q       <= S_IDLE;
            rem_q         <= 6'd0;
            tens_q        <= 4'd0;
            sec_snap_q    <= 6'd0;
            pend_q        <= '0;
            disp_q        <= '0;
            an_q          <= 4'b1111;
            seg_q         <= 7'b1111111;
            dp_q          <= 1'b1;
        end else begin
            presc_q       <= presc_d;
            idx_q         <= idx_d;
            first_q       <= first_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            state_q       <= state_d;
            rem_q         <= rem_d;
            tens_q        <= tens_d;
            sec_snap_q    <= sec_snap_d;
            pend_q        <= pend_d;
            disp_q        <= disp_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign conv_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: expected digit slots are queued per
// cycle when inputs are applied and compared as the display scans them out.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    typedef struct {
        int         cyc;
        int         frame;
        int         slot;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] min_i = 6'd0;
    logic [5:0] sec_i = 6'd0;
    logic       time_up = 1'b0;
    logic       paused = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       conv_busy;

    int   cyc;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .min(min_i), .sec(sec_i),
        .time_up(time_up), .paused(paused),
        .an(an), .seg(seg), .dp(dp), .conv_busy(conv_busy)
    );

    always #5 clk = ~clk;

    // Edges since reset release; edge 1 is the first frame start
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic push_frame(input int f, input int mn, input int sc, input bit blnk);
        exp_t       e;
        int         d;
        logic [3:0] one;
        one = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            case (s)
                0: d = sc % 10;
                1: d = sc / 10;
                2: d = mn % 10;
                default: d = mn / 10;
            endcase
            for (int c = 0; c < SD; c++) begin
                e.cyc   = f * FRAME + s * SD + 1 + c;
                e.frame = f;
                e.slot  = s;
                if (blnk) begin
                    e.an  = 4'b1111;
                    e.seg = 7'b1111111;
                    e.dp  = 1'b1;
                end else begin
                    e.an  = ~(one << s);
                    e.seg = ref_seg(d);
                    e.dp  = (s == 2) ? 1'b0 : 1'b1;
                end
                sb.push_back(e);
            end
        end
    endtask

    task automatic wait_cyc(input int k);
        int guard;
        guard = 0;
        while (cyc < k && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic apply_reset(input int mn, input int sc, input bit tu);
        rst_n   = 1'b0;
        min_i   = 6'(mn);
        sec_i   = 6'(sc);
        time_up = tu;
        paused  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        exp_t e;
        @(negedge clk);
        total++;
        if ({an, seg, dp, conv_busy} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got an=%b seg=%b dp=%b busy=%b want an=1111 seg=1111111 dp=1 busy=0",
                     an, seg, dp, conv_busy);
        end
        apply_reset(0, 0, 1'b0);
        push_frame(0, 0, 0, 1'b0);
        push_frame(1, 0, 0, 1'b0);
        while (sb.size() > 0) begin
            wait_cyc(sb[0].cyc);
            e = sb.pop_front();
            total++;
            if (cyc != e.cyc || {an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                bad++;
                $display("FAIL reset_frame f%0d d%0d cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         e.frame, e.slot, cyc, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_convert(input int mn, input int sc, input int busy_len);
        exp_t e;
        int   cnt;
        apply_reset(mn, sc, 1'b0);
        wait_cyc(1);
        cnt = 0;
        while (conv_busy === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        total++;
        if (cnt != busy_len) begin
            bad++;
            $display("FAIL convert_busy %0d:%0d got %0d cycles want %0d", mn, sc, cnt, busy_len);
        end
        push_frame(1, mn, sc, 1'b0);
        push_frame(2, mn, sc, 1'b0);
        while (sb.size() > 0) begin
            wait_cyc(sb[0].cyc);
            e = sb.pop_front();
            total++;
            if (cyc != e.cyc || {an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                bad++;
                $display("FAIL convert_frame %0d:%0d f%0d d%0d cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         mn, sc, e.frame, e.slot, cyc, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   mins[5];
        int   secs[5];
        mins = '{7, 40, 25, 9, 0};
        secs = '{59, 8, 61, 9, 45};
        apply_reset(mins[0], secs[0], 1'b0);
        push_frame(1, mins[0], secs[0], 1'b0);
        push_frame(2, mins[0], secs[0], 1'b0);
        for (int n = 1; n < 5; n++) begin
            wait_cyc(n * FRAME);
            min_i = 6'(mins[n]);
            sec_i = 6'(secs[n]);
            push_frame(n + 2, mins[n], secs[n], 1'b0);
            repeat (FRAME) begin
                wait_cyc(sb[0].cyc);
                e = sb.pop_front();
                total++;
                if (cyc != e.cyc || {an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                    bad++;
                    $display("FAIL b2b_frame f%0d d%0d cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                             e.frame, e.slot, cyc, an, seg, dp, e.an, e.seg, e.dp);
                end
            end
        end
        while (sb.size() > 0) begin
            wait_cyc(sb[0].cyc);
            e = sb.pop_front();
            total++;
            if (cyc != e.cyc || {an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                bad++;
                $display("FAIL b2b_frame f%0d d%0d cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         e.frame, e.slot, cyc, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_snapshot;
        exp_t e;
        apply_reset(0, 5, 1'b0);
        wait_cyc(1);
        total++;
        if (conv_busy !== 1'b1) begin
            bad++;
            $display("FAIL snapshot_busy got %b want 1", conv_busy);
        end
        sec_i = 6'd6;
        push_frame(1, 0, 5, 1'b0);
        push_frame(2, 0, 6, 1'b0);
        while (sb.size() > 0) begin
            wait_cyc(sb[0].cyc);
            e = sb.pop_front();
            total++;
            if (cyc != e.cyc || {an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                bad++;
                $display("FAIL snapshot_frame f%0d d%0d cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         e.frame, e.slot, cyc, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    task automatic test_blink;
        exp_t e;
        apply_reset(0, 0, 1'b1);
        push_frame(0, 0, 0, 1'b0);
        push_frame(1, 0, 0, 1'b1);
        push_frame(2, 0, 0, 1'b1);
        push_frame(3, 0, 0, 1'b0);
        push_frame(4, 0, 0, 1'b0);
        while (sb.size() > 0) begin
            wait_cyc(sb[0].cyc);
            e = sb.pop_front();
            total++;
            if (cyc != e.cyc || {an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                bad++;
                $display("FAIL blink_frame f%0d d%0d cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         e.frame, e.slot, cyc, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
        wait_cyc(5 * FRAME + SD + 2);
        total++;
        if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
            bad++;
            $display("FAIL blink_blank5 got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1", an, seg, dp);
        end
        time_up = 1'b0;
        @(negedge clk);
        total++;
        if ({an, seg, dp} !== {4'b1101, 7'b1000000, 1'b1}) begin
            bad++;
            $display("FAIL blink_release got an=%b seg=%b dp=%b want an=1101 seg=1000000 dp=1", an, seg, dp);
        end
        paused = 1'b1;
        @(negedge clk);
        total++;
        if (an !== 4'b1111 || seg !== 7'b1111111) begin
            bad++;
            $display("FAIL blink_paused got an=%b seg=%b want an=1111 seg=1111111", an, seg);
        end
        paused = 1'b0;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        apply_reset(12, 34, 1'b0);
        wait_cyc(FRAME + 1);
        total++;
        if ({an, seg, conv_busy} !== {4'b1110, 7'b0011001, 1'b1}) begin
            bad++;
            $display("FAIL midreset_pre got an=%b seg=%b busy=%b want an=1110 seg=0011001 busy=1",
                     an, seg, conv_busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({an, seg, dp, conv_busy} !== {4'b1111, 7'b1111111, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL midreset_async got an=%b seg=%b dp=%b busy=%b want an=1111 seg=1111111 dp=1 busy=0",
                     an, seg, dp, conv_busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(0, 0, 0, 1'b0);
        push_frame(1, 12, 34, 1'b0);
        while (sb.size() > 0) begin
            wait_cyc(sb[0].cyc);
            e = sb.pop_front();
            total++;
            if (cyc != e.cyc || {an, seg, dp} !== {e.an, e.seg, e.dp}) begin
                bad++;
                $display("FAIL midreset_frame f%0d d%0d cyc=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                         e.frame, e.slot, cyc, an, seg, dp, e.an, e.seg, e.dp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_convert(12, 34, 6);
        test_convert(63, 63, 14);
        test_back_to_back();
        test_snapshot();
        test_blink();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Display controller for the kitchen timer. Sequences the shared 4-digit common-anode 7-segment display: time-multiplexes the digits, converts the minute/second counts to decimal with an iterative divider, and blinks the display on time-up or pause.
- Sits between the timer FSM outputs (min, sec, timeUp, pause state) and the board anode/segment pins.

Parameters:
- SCAN_DIV, 50000, clk cycles each digit is driven; minimum 4.
- BLINK_DIV, 64, full scan frames per blink half-period; minimum 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- min  input  6  minutes from timer FSM, 0..63 accepted
- sec  input  6  seconds from timer FSM, 0..63 accepted
- time_up  input  1  timer expired; whole display blinks
- paused  input  1  timer paused; whole display blinks
- an  output  4  digit enables, active low; an[3] = leftmost digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active low
- dp  output  1  decimal point, active low
- conv_busy  output  1  high while the decimal converter is running

Behaviour:
- Reset (async, rst_n=0):
  - an=4'b1111, seg=7'b1111111, dp=1, conv_busy=0.
  - Prescaler=0, digit index=0, blink counter=0, blink_phase=1 (visible).
  - All committed and pending BCD digits=0.
- Prescaler counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→3→0.
- Frame start: the cycle where the index wraps 3→0 at terminal count, plus the first cycle after reset release. On each frame start:
  - Commit pending BCD to the displayed registers.
  - Snapshot min and sec.
  - Start conversion.
  - Step the blink counter.
- Conversion FSM:
  - IDLE: on frame start → MIN_DIV with the remainder loaded from the min snapshot and tens=0.
  - MIN_DIV: each cycle, if remainder ≥ 10 then subtract 10 and increment tens; otherwise store tens/ones as pending and → SEC_DIV loaded from the sec snapshot.
  - SEC_DIV: same step; when the remainder is < 10, store pending → IDLE.
  - conv_busy=1 in MIN_DIV and SEC_DIV. Worst case (63,63) is 14 busy cycles, which is less than the 4*SCAN_DIV frame.
  - Inputs of 60..63 display as tens digit 6 (e.g. 63 → "6","3"). No clamping.
- Digit mapping:
  - index 0 → an=4'b1110, sec ones.
  - index 1 → an=4'b1101, sec tens.
  - index 2 → an=4'b1011, min ones; dp=0 (colon substitute).
  - index 3 → an=4'b0111, min tens.
  - dp=1 on all other digits.
- Segment encoding, active low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Leading zeros are shown (not blanked).
- Outputs are registered. an, seg and dp reflect the index one clk after the index changes.
- Latency: an input change sampled at frame start F is displayed from frame F+1 onward. A whole frame always shows a consistent snapshot.
- Blink:
  - The blink counter counts frame starts 0..BLINK_DIV-1. On wrap, blink_phase toggles.
  - If (time_up|paused) and blink_phase=0: an=4'b1111, seg=7'b1111111, dp=1. Scanning and conversion continue internally.
  - When time_up and paused both drop, the display shows immediately on the next cycle. The blink counter and phase keep running; they are never reset except by rst_n.
- Input changes during conversion are ignored; the snapshot is held until the next frame start.
- Reset mid-conversion aborts to IDLE. Pending and committed digits clear to 0.

Test Plan:
- SCAN_DIV=4, BLINK_DIV=2; release reset with min=0, sec=0 → first frame shows an 1110/1101/1011/0111, each for 4 cycles, seg=1000000 on all four, dp=0 only while an=1011.
- min=12, sec=34 held → from the second frame: digit0 seg=0011001, digit1=0110000, digit2=1111001, digit3=0100100. conv_busy is high 1+1+3+1=... measured pulse of exactly 6 cycles (1+1 min steps, 3+1 sec steps) after each frame start.
- min=63, sec=63 → conv_busy high 14 cycles; displays "63:63" (tens seg=0000010, ones seg=0110000).
- time_up=1 with min=0, sec=0 → frames alternate 2 visible / 2 blank (an=1111, seg=1111111, dp=1). Drop time_up during a blank frame → next cycle digits visible.
- Change sec from 5 to 6 mid-conversion → current snapshot converts 5. Value 6 appears two frames later, never mid-frame.
- Assert rst_n=0 mid-frame during MIN_DIV → an=1111, seg=1111111, conv_busy=0 asynchronously. After release the first frame shows 0s.
